// File: rtl/mux32x1_reg.sv
// -----------------------------------------------------------------------------
// mux32x1_reg
//   Registered 32-to-1 single-bit multiplexer. On each rising clock edge where
//   in_valid is high, the bit in[sel] is captured into out and out_valid is
//   set. When in_valid is low, out keeps its last captured value and out_valid
//   clears. Both outputs come straight from flops, so there is no
//   combinational path from any input to any output.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset (out, out_valid -> 0)
//   in         in   N_IN   data bits; bit k is selected when sel == k
//   sel        in   SEL_W  index of the bit to forward (0..N_IN-1)
//   in_valid   in   1      qualifies in/sel for the current cycle
//   out        out  1      registered selected bit
//   out_valid  out  1      registered copy of in_valid; qualifies out
// -----------------------------------------------------------------------------
module mux32x1_reg #(
  parameter int N_IN  = 32,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  in,
  input  logic [SEL_W-1:0] sel,
  input  logic             in_valid,
  output logic             out,
  output logic             out_valid
);

  logic r_out;
  logic r_out_valid;
  logic w_sel_bit;

  // With N_IN a power of two every sel code maps to a real bit, so no range
  // check or clamping is needed. An X/Z sel makes the indexed read return X
  // in a 4-state simulator, which is then captured into out rather than
  // silently resolving to a legal bit; synthesis treats it as don't-care.
  assign w_sel_bit = in[sel];

  // NOTE: both flops sit on the asynchronous reset so rst_n=0 clears the
  // outputs immediately, without waiting for a clock edge; an in-flight
  // capture is simply lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from the
      // pre-edge values, independent of statement order.
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_out <= w_sel_bit;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux32x1_reg.sv
// -----------------------------------------------------------------------------
// tb_mux32x1_reg
//   Directed self-checking bench for mux32x1_reg. A table of hand-computed
//   vectors covers boundaries and walking-one patterns; a loop sweeps the
//   low-byte space; hand-written sequences cover reset, hold and mid-cycle
//   asynchronous reset.
// -----------------------------------------------------------------------------
module tb_mux32x1_reg;

  typedef struct {
    string       name;
    logic [31:0] in;
    logic [4:0]  sel;
    logic        exp_out;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] in;
  logic [4:0]  sel;
  logic        in_valid;
  logic        out;
  logic        out_valid;

  int n_checks;
  int n_fail;

  mux32x1_reg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .sel       (sel),
    .in_valid  (in_valid),
    .out       (out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs 1 time unit after an edge, then sample 1 unit after the next.
  task automatic step(input logic [31:0] d, input logic [4:0] s, input logic v);
    in       = d;
    sel      = s;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // ---- vector table -------------------------------------------------------
    vecs.push_back('{"b31_msb",     32'h8000_0000, 5'd31, 1'b1});
    vecs.push_back('{"b0_lsb_clr",  32'hFFFF_FFFE, 5'd0,  1'b0});
    vecs.push_back('{"b3_ex",       32'h0000_0008, 5'd3,  1'b1});
    vecs.push_back('{"b31_clr",     32'h7FFF_FFFF, 5'd31, 1'b0});
    vecs.push_back('{"b0_set",      32'h0000_0001, 5'd0,  1'b1});
    vecs.push_back('{"b16_a5",      32'hA5A5_5A5A, 5'd16, 1'b1});
    vecs.push_back('{"b17_a5",      32'hA5A5_5A5A, 5'd17, 1'b0});
    for (int k = 0; k < 32; k++) begin
      vecs.push_back('{$sformatf("walk%0d_hit", k),  32'h1 << k, 5'(k),          1'b1});
      vecs.push_back('{$sformatf("walk%0d_miss", k), 32'h1 << k, 5'((k + 1) % 32), 1'b0});
    end

    // ---- 1. reset ----------------------------------------------------------
    rst_n    = 1'b0;
    in       = 32'hFFFF_FFFF;
    sel      = 5'd5;
    in_valid = 1'b1;
    #1;
    check("rst_out_async", out, 1'b0);
    check("rst_vld_async", out_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_out_hold", out, 1'b0);
      check("rst_vld_hold", out_valid, 1'b0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rel_out", out, 1'b1);
    check("rst_rel_vld", out_valid, 1'b1);

    // ---- 3/4. table ----------------------------------------------------------
    foreach (vecs[i]) begin
      step(vecs[i].in, vecs[i].sel, 1'b1);
      check(vecs[i].name, out, vecs[i].exp_out);
      check({vecs[i].name, "_vld"}, out_valid, 1'b1);
    end

    // ---- 2. low-byte sweep ---------------------------------------------------
    for (int s = 0; s < 32; s++) begin
      for (int d = 0; d < 256; d++) begin
        logic exp_b;
        exp_b = (s < 8) ? ((d >> s) & 1) != 0 : 1'b0;
        step(32'(d), 5'(s), 1'b1);
        check($sformatf("sweep_s%0d_d%0d", s, d), out, exp_b);
      end
    end

    // ---- 5. hold with in_valid=0 --------------------------------------------
    step(32'h0000_0400, 5'd10, 1'b1);
    check("hold_cap_out", out, 1'b1);
    check("hold_cap_vld", out_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(32'h0, 5'd10, 1'b0);
      check("hold_out", out, 1'b1);
      check("hold_vld", out_valid, 1'b0);
    end
    // Resume: the next valid cycle captures again.
    step(32'h0, 5'd10, 1'b1);
    check("resume_out", out, 1'b0);
    check("resume_vld", out_valid, 1'b1);

    // ---- sel change between edges has no effect ------------------------------
    step(32'h0000_0002, 5'd1, 1'b1);
    check("selchg_cap", out, 1'b1);
    sel = 5'd0;
    in  = 32'h0;
    #3;
    check("selchg_nocomb_out", out, 1'b1);
    check("selchg_nocomb_vld", out_valid, 1'b1);
    @(posedge clk);
    #1;
    check("selchg_next_edge", out, 1'b0);

    // ---- 6. async reset mid-run ---------------------------------------------
    step(32'hFFFF_FFFF, 5'd20, 1'b1);
    check("arst_pre_out", out, 1'b1);
    check("arst_pre_vld", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_drop_out", out, 1'b0);
    check("arst_drop_vld", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check("arst_discard_out", out, 1'b0);
    check("arst_discard_vld", out_valid, 1'b0);
    rst_n = 1'b1;
    step(32'h0000_0000, 5'd20, 1'b0);
    check("arst_post_idle_out", out, 1'b0);
    check("arst_post_idle_vld", out_valid, 1'b0);
    step(32'h0010_0000, 5'd20, 1'b1);
    check("arst_post_cap_out", out, 1'b1);
    check("arst_post_cap_vld", out_valid, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
